// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, times mid-bit sampling from a latched
// divisor, assembles 8N1 bytes and presents them through a valid/ready holding register.
module uart_rx_ctrl #(
  parameter int BAUD_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_en_i,
  input  logic [BAUD_W-1:0] baud_i,
  input  logic              rx_in_i,
  input  logic              rx_ready_i,
  output logic [7:0]        rx_data_o,
  output logic              rx_valid_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o,
  output logic [3:0]        bit_cnt_out_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  state_t            state_q;
  logic              sync1_q, rxs_q, rxs_dly_q;
  logic [BAUD_W-1:0] bcnt_q, bdiv_q;
  logic [3:0]        bidx_q;
  logic [7:0]        shift_q, rx_data_q;
  logic              rx_valid_q, frame_err_q, overrun_q;

  logic half_hit, bit_hit, reg_free;

  assign half_hit = (bcnt_q == ((bdiv_q >> 1) - ONE));
  assign bit_hit  = (bcnt_q == (bdiv_q - ONE));
  // Holding register is free when empty or being drained on this same edge.
  assign reg_free = !rx_valid_q || rx_ready_i;

  // Handshake: a byte moves on every edge with rx_valid_o & rx_ready_i; rx_data_o
  // is stable while rx_valid_o is high and no transfer happens.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_dly_q   <= 1'b1;
      bcnt_q      <= '0;
      bdiv_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_in_i;
      rxs_q       <= sync1_q;
      rxs_dly_q   <= rxs_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          bcnt_q <= '0;
          bidx_q <= '0;
          if (rx_en_i && rxs_dly_q && !rxs_q) begin
            bdiv_q  <= baud_i;
            state_q <= START;
          end
        end
        START: begin
          if (!rx_en_i) begin
            state_q <= IDLE;
          end else if (half_hit) begin
            bcnt_q  <= '0;
            bidx_q  <= '0;
            state_q <= rxs_q ? IDLE : DATA;
          end else begin
            bcnt_q <= bcnt_q + ONE;
          end
        end
        DATA: begin
          if (!rx_en_i) begin
            bidx_q  <= '0;
            state_q <= IDLE;
          end else if (bit_hit) begin
            shift_q <= {rxs_q, shift_q[7:1]};
            bidx_q  <= bidx_q + 4'd1;
            bcnt_q  <= '0;
            if (bidx_q == 4'd7) state_q <= STOP;
          end else begin
            bcnt_q <= bcnt_q + ONE;
          end
        end
        STOP: begin
          if (!rx_en_i) begin
            bidx_q  <= '0;
            state_q <= IDLE;
          end else if (bit_hit) begin
            bidx_q  <= '0;
            bcnt_q  <= '0;
            state_q <= IDLE;
            if (!rxs_q) begin
              frame_err_q <= 1'b1;
            end else if (reg_free) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = (state_q != IDLE);
  assign bit_cnt_out_o = bidx_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-scenario tasks drive serial frames cycle by
// cycle, record output events relative to the start edge and compare against hand values.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en;
  logic [19:0] baud;
  logic        rx_in;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;
  logic [3:0]  bit_cnt;

  int errors = 0;
  int checks = 0;

  uart_rx_ctrl #(.BAUD_W(20)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_en_i      (rx_en),
    .baud_i       (baud),
    .rx_in_i      (rx_in),
    .rx_ready_i   (rx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .busy_o       (busy),
    .bit_cnt_out_o(bit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // Line pattern, one entry per clock cycle, and per-run observations.
  bit       line_q[$];
  int       load_k_q[$];
  bit [7:0] load_d_q[$];
  int       busy_cycles, valid_hi, valid_lo, ferr_cnt, ferr_k, ovr_cnt, ovr_k;
  int       bc_max, bc_bad;
  bit       abort_busy;
  bit [7:0] rst_data;
  bit       rst_valid, rst_busy, rst_ferr, rst_ovr;
  bit [3:0] rst_bc;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_level(input bit v, input int n);
    repeat (n) line_q.push_back(v);
  endtask

  task automatic push_frame(input bit [7:0] d, input int b, input bit stop_bit);
    push_level(1'b0, b);
    for (int i = 0; i < 8; i++) push_level(d[i], b);
    push_level(stop_bit, b);
  endtask

  function automatic int first_load_k();
    return (load_k_q.size() > 0) ? load_k_q[0] : -1;
  endfunction

  function automatic int first_load_d();
    return (load_d_q.size() > 0) ? int'(load_d_q[0]) : -1;
  endfunction

  // Cycle k drives line_q[k]; the following rising edge is E0+k when line_q[0] is
  // the start bit. Outputs are observed on the falling edge after that.
  task automatic run_line(input bit rdy, input int rdy_k, input int abort_k, input int rst_k);
    bit       prev_v;
    bit [7:0] prev_d;
    int       prev_bc;
    int       n;
    n = line_q.size();
    load_k_q.delete();
    load_d_q.delete();
    busy_cycles = 0; valid_hi = 0; valid_lo = 0;
    ferr_cnt = 0; ferr_k = -1; ovr_cnt = 0; ovr_k = -1;
    bc_max = 0; bc_bad = 0;
    prev_v = rx_valid; prev_d = rx_data; prev_bc = int'(bit_cnt);
    for (int k = 0; k < n; k++) begin
      rx_in    = line_q[k];
      rx_ready = (k == rdy_k) ? 1'b1 : rdy;
      if (k == abort_k) rx_en = 1'b0;
      rst = (k == rst_k) ? 1'b0 : 1'b1;
      tick();
      if (busy) busy_cycles++;
      if (rx_valid) valid_hi++; else valid_lo++;
      if (frame_err) begin ferr_cnt++; ferr_k = k; end
      if (overrun) begin ovr_cnt++; ovr_k = k; end
      if (rx_valid && (!prev_v || rx_data !== prev_d)) begin
        load_k_q.push_back(k);
        load_d_q.push_back(rx_data);
      end
      if (int'(bit_cnt) != prev_bc && bit_cnt != 4'd0 && int'(bit_cnt) != prev_bc + 1) bc_bad++;
      if (int'(bit_cnt) > bc_max) bc_max = int'(bit_cnt);
      if (k == abort_k) abort_busy = busy;
      if (k == rst_k) begin
        rst_data = rx_data; rst_valid = rx_valid; rst_busy = busy;
        rst_ferr = frame_err; rst_ovr = overrun; rst_bc = bit_cnt;
      end
      prev_v = rx_valid; prev_d = rx_data; prev_bc = int'(bit_cnt);
    end
    line_q.delete();
    rx_ready = rdy;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_en = 1'b1; baud = 20'd16; rx_in = 1'b1; rx_ready = 1'b0;
    repeat (3) tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%0d exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%0d exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bitcnt got=%0d exp=0", bit_cnt); end
    rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    baud = 20'd16;
    push_frame(8'hA5, 16, 1'b1);
    push_level(1'b1, 10);
    run_line(1'b1, -1, -1, -1);
    checks++; if (first_load_k() != 154) begin errors++; $display("FAIL basic_load_edge got=%0d exp=154", first_load_k()); end
    checks++; if (first_load_d() != 'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", first_load_d()); end
    checks++; if (valid_hi != 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_hi); end
    checks++; if (busy_cycles != 152) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=152", busy_cycles); end
    checks++; if (bc_max != 8) begin errors++; $display("FAIL basic_bitcnt_max got=%0d exp=8", bc_max); end
    checks++; if (bc_bad != 0) begin errors++; $display("FAIL basic_bitcnt_steps got=%0d exp=0", bc_bad); end
    checks++; if (ferr_cnt + ovr_cnt != 0) begin errors++; $display("FAIL basic_flags got=%0d exp=0", ferr_cnt + ovr_cnt); end
  endtask

  task automatic test_backpressure();
    baud = 20'd8;
    push_frame(8'h3C, 8, 1'b1);
    push_level(1'b1, 2);
    run_line(1'b0, -1, -1, -1);
    checks++; if (first_load_k() != 78) begin errors++; $display("FAIL bp_load_edge got=%0d exp=78", first_load_k()); end
    checks++; if (first_load_d() != 'h3C) begin errors++; $display("FAIL bp_data got=%h exp=3c", first_load_d()); end
    push_frame(8'hC3, 8, 1'b1);
    push_level(1'b1, 2);
    run_line(1'b0, -1, -1, -1);
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL bp_ovr_pulses got=%0d exp=1", ovr_cnt); end
    checks++; if (ovr_k != 78) begin errors++; $display("FAIL bp_ovr_edge got=%0d exp=78", ovr_k); end
    checks++; if (load_k_q.size() != 0) begin errors++; $display("FAIL bp_no_reload got=%0d exp=0", load_k_q.size()); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL bp_held_data got=%h exp=3c", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got=%0d exp=1", rx_valid); end
    rx_ready = 1'b1;
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got=%0d exp=0", rx_valid); end
    rx_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    baud = 20'd8;
    push_frame(8'h11, 8, 1'b1);
    push_level(1'b1, 2);
    run_line(1'b0, -1, -1, -1);
    checks++; if (first_load_d() != 'h11) begin errors++; $display("FAIL sim_first_data got=%h exp=11", first_load_d()); end
    push_frame(8'h22, 8, 1'b1);
    push_level(1'b1, 2);
    run_line(1'b0, 78, -1, -1);
    checks++; if (first_load_k() != 78) begin errors++; $display("FAIL sim_load_edge got=%0d exp=78", first_load_k()); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL sim_data got=%h exp=22", rx_data); end
    checks++; if (valid_lo != 0) begin errors++; $display("FAIL sim_valid_low_cycles got=%0d exp=0", valid_lo); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL sim_ovr got=%0d exp=0", ovr_cnt); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_framing();
    baud = 20'd10;
    push_frame(8'h55, 10, 1'b0);
    push_level(1'b0, 30);
    push_level(1'b1, 20);
    run_line(1'b1, -1, -1, -1);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL fe_pulses got=%0d exp=1", ferr_cnt); end
    checks++; if (ferr_k != 97) begin errors++; $display("FAIL fe_edge got=%0d exp=97", ferr_k); end
    checks++; if (valid_hi != 0) begin errors++; $display("FAIL fe_valid got=%0d exp=0", valid_hi); end
    checks++; if (busy_cycles != 95) begin errors++; $display("FAIL fe_busy_cycles got=%0d exp=95", busy_cycles); end
    push_frame(8'h0F, 10, 1'b1);
    push_level(1'b1, 5);
    run_line(1'b1, -1, -1, -1);
    checks++; if (first_load_k() != 97) begin errors++; $display("FAIL fe_next_edge got=%0d exp=97", first_load_k()); end
    checks++; if (first_load_d() != 'h0F) begin errors++; $display("FAIL fe_next_data got=%h exp=0f", first_load_d()); end
  endtask

  task automatic test_false_start();
    baud = 20'd16;
    push_level(1'b0, 3);
    push_level(1'b1, 30);
    run_line(1'b1, -1, -1, -1);
    checks++; if (busy_cycles != 8) begin errors++; $display("FAIL fs_busy_cycles got=%0d exp=8", busy_cycles); end
    checks++; if (ferr_cnt + ovr_cnt != 0) begin errors++; $display("FAIL fs_flags got=%0d exp=0", ferr_cnt + ovr_cnt); end
    checks++; if (valid_hi != 0) begin errors++; $display("FAIL fs_valid got=%0d exp=0", valid_hi); end
  endtask

  task automatic test_abort();
    baud = 20'd8;
    push_frame(8'h5A, 8, 1'b1);
    push_level(1'b1, 4);
    run_line(1'b1, -1, 30, -1);
    checks++; if (abort_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0d exp=0", abort_busy); end
    checks++; if (busy_cycles != 28) begin errors++; $display("FAIL abort_busy_cycles got=%0d exp=28", busy_cycles); end
    checks++; if (valid_hi + ferr_cnt + ovr_cnt != 0) begin errors++; $display("FAIL abort_outputs got=%0d exp=0", valid_hi + ferr_cnt + ovr_cnt); end
    rx_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_midframe();
    baud = 20'd8;
    push_frame(8'h99, 8, 1'b1);
    push_level(1'b1, 2);
    run_line(1'b0, -1, -1, -1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got=%0d exp=1", rx_valid); end
    push_frame(8'h66, 8, 1'b1);
    push_level(1'b1, 4);
    run_line(1'b0, -1, -1, 75);
    checks++; if (rst_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%0d exp=0", rst_valid); end
    checks++; if (rst_data !== 8'h00) begin errors++; $display("FAIL rm_data got=%h exp=00", rst_data); end
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%0d exp=0", rst_busy); end
    checks++; if (rst_bc !== 4'd0) begin errors++; $display("FAIL rm_bitcnt got=%0d exp=0", rst_bc); end
    checks++; if ({rst_ferr, rst_ovr} !== 2'b00) begin errors++; $display("FAIL rm_flags got=%b exp=00", {rst_ferr, rst_ovr}); end
  endtask

  task automatic test_back_to_back();
    baud = 20'd8;
    push_frame(8'h81, 8, 1'b1);
    push_frame(8'h7E, 8, 1'b1);
    push_level(1'b1, 5);
    run_line(1'b1, -1, -1, -1);
    checks++; if (load_k_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", load_k_q.size()); end
    checks++; if (first_load_d() != 'h81) begin errors++; $display("FAIL b2b_data0 got=%h exp=81", first_load_d()); end
    checks++; if (load_k_q.size() > 1 && load_k_q[1] != 158) begin errors++; $display("FAIL b2b_edge1 got=%0d exp=158", load_k_q[1]); end
    checks++; if (load_d_q.size() > 1 && load_d_q[1] != 8'h7E) begin errors++; $display("FAIL b2b_data1 got=%h exp=7e", load_d_q[1]); end
    checks++; if (valid_hi != 2) begin errors++; $display("FAIL b2b_valid_cycles got=%0d exp=2", valid_hi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_framing();
    test_false_start();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART block. It synchronises the raw serial line, detects the start bit, and times mid-bit sampling from a programmable baud divisor. It shifts in 8 data bits LSB-first, checks the stop bit, and hands the byte to the consumer through a valid/ready holding register. It replaces the free-running bit/baud counter pair with a single FSM-driven controller, and adds framing-error and overrun reporting.

## Interface
- BAUD_W, 20, width of baud divisor and internal baud counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- rx_en  in  1  receiver enable; 0 forces IDLE
- baud  in  BAUD_W  clock cycles per bit; legal range 4..2^BAUD_W-1; sampled at start-bit detection and held for the frame
- rx_in  in  1  raw asynchronous serial line, idle high
- rx_ready  in  1  consumer accepts byte when high with rx_valid
- rx_data  out  8  received byte (holding register)
- rx_valid  out  1  rx_data holds an unconsumed byte
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: completed byte dropped because holding register full
- busy  out  1  high in any state other than IDLE
- bit_cnt_out  out  4  data-bit index 0..8 in current frame (0 outside DATA/STOP)

## Operation
- Synchroniser: two flops on rx_in, reset to 1; the FSM uses only the second flop (rxs) and its one-cycle-delayed copy (rxs_d, reset 1).
- States: IDLE, START, DATA, STOP. Baud counter bcnt (BAUD_W bits) and bit index bidx (4 bits); divisor latch bdiv.
- IDLE: busy=0. If rx_en & rxs_d==1 & rxs==0 (falling edge), latch bdiv=baud, clear bcnt, go to START.
- START: bcnt increments each cycle. When bcnt==(bdiv>>1)-1: if rxs==0, clear bcnt and bidx and go to DATA; else, on a false start, go to IDLE with no flags.
- DATA: bcnt increments. When bcnt==bdiv-1: shift rxs into shift register MSB, right shift (first bit received ends in bit 0), bidx++, clear bcnt. After the sample making bidx==8, go to STOP.
- STOP: when bcnt==bdiv-1, sample rxs and go to IDLE:
  - rxs==1 with holding register free: load rx_data and set rx_valid. A register is free if rx_valid==0, or if rx_valid & rx_ready hold in the same cycle.
  - rxs==1 with holding register full: pulse overrun. Old byte and rx_valid are unchanged; new byte is dropped.
  - rxs==0: pulse frame_err and discard the byte. No re-arm occurs until the line returns high, because edge detection requires rxs_d==1.
- Handshake: a transfer occurs on any edge where rx_valid & rx_ready. rx_valid clears on that edge unless a new byte loads on the same edge, in which case it stays 1 with the new data. rx_data is stable while rx_valid==1 and no transfer occurs.
- rx_en deassertion in START, DATA or STOP: the next state is IDLE and the partial byte is discarded with no flags. The holding register and rx_valid are unaffected; the handshake still operates with rx_en=0.
- Mid-frame changes on baud are ignored; only bdiv is used.

## Timing
- Reset (rst==0 at an edge): state IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, bit_cnt_out=0, bcnt=0, bidx=0, synchroniser flops=1. Reset takes priority over all other events.
- Let edge E0 be the first edge at which the first synchroniser flop captures rx_in low. Then:
  - START is entered after E0+2.
  - The start sample occurs at E0+2+(bdiv>>1).
  - Data bit i (i=0..7) is sampled at E0+2+(bdiv>>1)+(i+1)*bdiv.
  - The stop sample occurs at E0+2+(bdiv>>1)+9*bdiv; rx_valid/frame_err/overrun are visible after this edge.
- frame_err and overrun are high for exactly one cycle.
- Back-to-back frames are supported: IDLE is re-entered the cycle after the stop sample, before the next start edge arrives.

## Test plan
- Basic rx: baud=16, send 0xA5 (8N1, 16 clk/bit), rx_ready=1. Required: rx_valid high one cycle at edge E0+154 with rx_data=0xA5, bit_cnt_out stepping 0..8.
- Backpressure and overrun: baud=8, send 0x3C then 0xC3 with rx_ready=0. Required: rx_data=0x3C held, rx_valid=1, overrun pulses once at the second stop sample. Raising rx_ready then clears rx_valid the next edge.
- Simultaneous consume and load: rx_valid=1 (0x11), rx_ready asserted exactly on the stop-sample edge of 0x22. Required: rx_data=0x22, rx_valid stays 1, overrun=0.
- Framing error: baud=10, send 0x55 with stop bit 0, line held low for 30 cycles then high. Required: one frame_err pulse, rx_valid unchanged, no new start detected until the line returns high; a following 0x0F is received correctly.
- False start: baud=16, low glitch of 3 cycles. Required: return to IDLE at the start sample, busy high about 8 cycles, no flags, no rx_valid.
- Abort and reset: drop rx_en mid-DATA, which must give IDLE next cycle and no output. Then assert rst=0 mid-frame with rx_valid=1, which must clear all outputs to 0 on that edge.
